// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts a load/store request level, waits a fixed
// number of cycles, performs the access on a word-addressed RAM and pulses a
// one-cycle ack that releases the requester's stall.
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_ack_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // A request is an error when it is misaligned or asks for both directions.
  function automatic logic req_error(input logic [1:0] addr_lo, input logic rd, input logic wr);
    req_error = (addr_lo != 2'b00) | (rd & wr);
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH];

  state_t            state_r;
  state_t            next_state_s;
  logic [3:0]        cnt_r;
  logic [ADDR_W-1:0] idx_r;
  logic [DATA_W-1:0] wdata_r;
  logic              rd_r;
  logic              wr_r;
  logic              lat_err_r;
  logic [DATA_W-1:0] rdata_r;
  logic              ack_r;
  logic              err_r;
  logic              busy_r;

  logic              req_s;
  logic [ADDR_W-1:0] eff_idx_s;
  logic [DATA_W-1:0] eff_wdata_s;
  logic              eff_rd_s;
  logic              eff_wr_s;
  logic              eff_err_s;
  logic              enter_resp_s;
  logic              mem_we_s;
  logic              unused_addr_s;

  // Upper address bits only alias the word space; they are deliberately dropped.
  assign unused_addr_s = ^addr_i[31:ADDR_W+2];

  // Transaction attributes: taken straight from the inputs on the accepting
  // edge (needed when there are no wait states), otherwise from the latches.
  always_comb begin
    req_s       = mem_read_i | mem_write_i;
    eff_idx_s   = idx_r;
    eff_wdata_s = wdata_r;
    eff_rd_s    = rd_r;
    eff_wr_s    = wr_r;
    eff_err_s   = lat_err_r;
    if (state_r == S_IDLE) begin
      eff_idx_s   = addr_i[ADDR_W+1:2];
      eff_wdata_s = wdata_i;
      eff_rd_s    = mem_read_i;
      eff_wr_s    = mem_write_i;
      eff_err_s   = req_error(addr_i[1:0], mem_read_i, mem_write_i);
    end else begin
      eff_idx_s   = idx_r;
    end
  end

  // Next-state selection for the request/wait/response sequence.
  always_comb begin
    next_state_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (req_s) begin
          if (WAIT_CNT == 4'd0) begin
            next_state_s = S_RESP;
          end else begin
            next_state_s = S_WAIT;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r <= 4'd1) begin
          next_state_s = S_RESP;
        end else begin
          next_state_s = S_WAIT;
        end
      end
      S_RESP:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  assign enter_resp_s = (next_state_s == S_RESP) && (state_r != S_RESP);
  // Gating with reset guarantees an interrupted store can never land.
  assign mem_we_s     = enter_resp_s & eff_wr_s & ~eff_err_s & rst_ni;

  // Control FSM with registered ack/err/busy/rdata outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= S_IDLE;
      cnt_r     <= 4'd0;
      idx_r     <= '0;
      wdata_r   <= '0;
      rd_r      <= 1'b0;
      wr_r      <= 1'b0;
      lat_err_r <= 1'b0;
      rdata_r   <= '0;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != S_IDLE);
      ack_r   <= enter_resp_s;
      err_r   <= enter_resp_s & eff_err_s;
      case (state_r)
        S_IDLE: begin
          if (req_s) begin
            idx_r     <= addr_i[ADDR_W+1:2];
            wdata_r   <= wdata_i;
            rd_r      <= mem_read_i;
            wr_r      <= mem_write_i;
            lat_err_r <= req_error(addr_i[1:0], mem_read_i, mem_write_i);
            cnt_r     <= WAIT_CNT;
          end
        end
        S_WAIT: begin
          if (cnt_r > 4'd1) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            cnt_r <= 4'd0;
          end
        end
        S_RESP:  cnt_r <= 4'd0;
        default: cnt_r <= 4'd0;
      endcase
      if (enter_resp_s) begin
        if (eff_err_s) begin
          rdata_r <= '0;
        end else if (eff_rd_s) begin
          rdata_r <= mem_r[eff_idx_s];
        end
      end
    end
  end

  // RAM write port; contents are intentionally not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      mem_r[eff_idx_s] <= eff_wdata_s;
    end
  end

  assign rdata_o   = rdata_r;
  assign mem_ack_o = ack_r;
  assign err_o     = err_r;
  assign busy_o    = busy_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: unit 0 runs with two wait states, unit 1 with none.
module tb_data_mem_responder;

  localparam int WS0 = 2;
  localparam int WS1 = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ack   [2];
  logic        err   [2];
  logic        busy  [2];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl_mem  [2][256];
  logic [31:0] mdl_last [2];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    bit          chk_rd;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(WS0)) u_dut_ws2 (
    .clk_i(clk), .rst_ni(rst_n), .mem_read_i(rd[0]), .mem_write_i(wr[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]),
    .mem_ack_o(ack[0]), .err_o(err[0]), .busy_o(busy[0]));

  data_mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(WS1)) u_dut_ws0 (
    .clk_i(clk), .rst_ni(rst_n), .mem_read_i(rd[1]), .mem_write_i(wr[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]),
    .mem_ack_o(ack[1]), .err_o(err[1]), .busy_o(busy[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Reference behaviour: word-indexed memory, aliasing by dropping upper bits.
  function automatic void model_apply(input int u, input logic r, input logic w,
                                      input logic [31:0] a, input logic [31:0] d,
                                      output logic e, output logic [31:0] q);
    int wi;
    wi = int'(a[9:2]);
    e  = (a[1:0] != 2'b00) || (r && w);
    if (e) begin
      q = 32'h0;
      mdl_last[u] = q;
    end else if (r) begin
      q = mdl_mem[u][wi];
      mdl_last[u] = q;
    end else begin
      mdl_mem[u][wi] = d;
      q = mdl_last[u];
    end
  endfunction

  // Drive one request, count cycles to ack, and capture the response.
  task automatic do_txn(input int u, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input bit drop,
                        output int lat, output logic e, output logic [31:0] q, output bit busy_ok);
    lat = 0; e = 1'b0; q = 32'h0; busy_ok = 1'b1;
    @(negedge clk);
    rd[u] = r; wr[u] = w; addr[u] = a; wdata[u] = d;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy[u] !== 1'b1) busy_ok = 1'b0;
      if (ack[u] === 1'b1) begin
        lat = k; e = err[u]; q = rdata[u];
        rd[u] = 1'b0; wr[u] = 1'b0;
        break;
      end
      if (drop) begin
        rd[u] = 1'b0; wr[u] = 1'b0;
      end
    end
    rd[u] = 1'b0; wr[u] = 1'b0;
  endtask

  task automatic run_txn(input int u, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input bit drop, input string name,
                         output logic e, output logic [31:0] q);
    int          lat;
    bit          bok;
    logic        me;
    logic [31:0] mq;
    do_txn(u, r, w, a, d, drop, lat, e, q, bok);
    model_apply(u, r, w, a, d, me, mq);
    chk({name, "_lat"}, 32'(lat), (u == 0) ? 32'(WS0 + 1) : 32'(WS1 + 1));
    chk_bit({name, "_err"}, e, me);
    chk({name, "_rdata"}, q, mq);
    chk_bit({name, "_busy"}, bok, 1'b1);
  endtask

  initial begin
    logic        e;
    logic [31:0] q;
    int          idx;

    vecs[0] = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 32'h12,  32'hBAD0BAD0, 1'b1, 32'h0,        1'b1};
    vecs[3] = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 32'h10,  32'h11111111, 1'b1, 32'h0,        1'b1};
    vecs[5] = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 32'h400, 32'h5A5A5A5A, 1'b0, 32'h0,        1'b0};
    vecs[7] = '{1'b1, 1'b0, 32'h000, 32'h0,        1'b0, 32'h5A5A5A5A, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 32'h20,  32'h12345678, 1'b0, 32'h0,        1'b0};
    vecs[9] = '{1'b1, 1'b0, 32'h20,  32'h0,        1'b0, 32'h12345678, 1'b1};

    for (int u = 0; u < 2; u++) begin
      rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = 32'h0; wdata[u] = 32'h0;
      mdl_last[u] = 32'h0;
    end

    // Reset state
    #12;
    for (int u = 0; u < 2; u++) begin
      chk_bit("rst_ack", ack[u], 1'b0);
      chk_bit("rst_busy", busy[u], 1'b0);
      chk_bit("rst_err", err[u], 1'b0);
      chk("rst_rdata", rdata[u], 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Preload the first 16 words of both memories
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 16; i++) begin
        run_txn(u, 1'b0, 1'b1, 32'(i * 4), (u == 1) ? 32'(i + 1) : $urandom, 1'b0, "pre", e, q);
      end
    end

    // Directed table on the two-wait-state unit
    for (int i = 0; i < 10; i++) begin
      run_txn(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, "tbl", e, q);
      chk_bit("tbl_exp_err", e, vecs[i].exp_err);
      if (vecs[i].chk_rd) chk("tbl_exp_rdata", q, vecs[i].exp_rdata);
    end

    // Back-to-back loads with the level held, zero wait states
    @(negedge clk);
    idx = 0;
    rd[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk_bit("b2b_ack", ack[1], (k == 1 || k == 3 || k == 5) ? 1'b1 : 1'b0);
      if (ack[1] === 1'b1) begin
        chk("b2b_rdata", rdata[1], 32'(idx + 1));
        idx++;
        addr[1] = 32'(idx * 4);
        if (idx == 3) rd[1] = 1'b0;
      end
    end
    rd[1] = 1'b0;
    mdl_last[1] = 32'h3;

    // Reset in the middle of a write's wait phase
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hCAFEF00D;
    @(negedge clk);
    chk_bit("rstw_busy_before", busy[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk_bit("rstw_ack", ack[u], 1'b0);
      chk_bit("rstw_busy", busy[u], 1'b0);
      chk_bit("rstw_err", err[u], 1'b0);
      chk("rstw_rdata", rdata[u], 32'h0);
      mdl_last[u] = 32'h0;
    end
    wr[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk_bit("rstw_no_ack", ack[0], 1'b0);
    end
    run_txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, "rstw_read", e, q);
    chk("rstw_old_value", q, 32'h12345678);

    // Randomised traffic against the reference model
    for (int i = 0; i < 120; i++) begin
      int          u;
      int          op;
      logic        r;
      logic        w;
      logic [31:0] a;
      u  = $urandom_range(0, 1);
      op = $urandom_range(0, 9);
      r  = (op <= 3 || op >= 8) ? 1'b1 : 1'b0;
      w  = (op >= 4 && op <= 8) ? 1'b1 : 1'b0;
      a  = $urandom;
      a[9:2] = 8'($urandom_range(0, 15));
      a[1:0] = (op == 9 || $urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(u, r, w, a, $urandom, ($urandom_range(0, 3) == 0), "rnd", e, q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
